// File: rtl/npu_mac_accum.sv
// npu_mac_accum: accumulate, bias, round, shift and saturate stage
// placed after the MULTADDALU dot-product datapath.
//
// Optional feature macro: NPU_ACC_RELU_EN (negative results output 0).
//
// Ports:
//   clk, reset_n         clock, synchronous active-low reset
//   in_valid/in_ready    product beat handshake
//   in_data, in_last     signed product, last beat of dot product
//   bias, shift_amt      sampled with the in_last beat
//   out_valid/out_ready  result handshake toward writeback
//   out_data             saturated signed activation
//   ovf_flag, sat_flag   sticky accumulator overflow / output clamp
module npu_mac_accum #(
  parameter int IN_W   = 37,
  parameter int ACC_W  = 48,
  parameter int BIAS_W = 32,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_last,
  input  logic [BIAS_W-1:0] bias,
  input  logic [5:0]        shift_amt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              ovf_flag,
  output logic              sat_flag
);

  localparam logic [5:0] SHIFT_MAX = 6'(ACC_W - 1);

  localparam logic signed [ACC_W:0] Q_MAX =
    (ACC_W+1)'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [ACC_W:0] Q_MIN = ~Q_MAX;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] in_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] sum1;
  logic signed [ACC_W-1:0] sum2;
  logic                    ovf1;
  logic                    ovf2;

  logic                    pend_valid;
  logic signed [ACC_W-1:0] pend_sum;
  logic [5:0]              pend_shift;

  logic                    accept;
  logic                    xfer;
  logic                    ovf_hit;
  logic [5:0]              shift_eff;

  logic signed [ACC_W:0]   wide;
  logic signed [ACC_W:0]   round_k;
  logic signed [ACC_W:0]   rnd;
  logic signed [ACC_W:0]   shifted;
  logic [OUT_W-1:0]        q;
  logic                    clamp;

  assign in_ext   = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
  assign bias_ext = {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias};

  // Overflow: operands share a sign the result does not.
  assign sum1 = acc + in_ext;
  assign ovf1 = (acc[ACC_W-1] == in_ext[ACC_W-1]) &&
                (sum1[ACC_W-1] != acc[ACC_W-1]);
  assign sum2 = sum1 + bias_ext;
  assign ovf2 = (sum1[ACC_W-1] == bias_ext[ACC_W-1]) &&
                (sum2[ACC_W-1] != sum1[ACC_W-1]);

  assign in_ready = !pend_valid || !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign xfer     = pend_valid && (!out_valid || out_ready);
  assign ovf_hit  = accept && (ovf1 || (in_last && ovf2));

  assign shift_eff = (shift_amt > SHIFT_MAX) ? SHIFT_MAX : shift_amt;

  // One guard bit keeps the half-LSB rounding add from wrapping.
  assign wide    = {pend_sum[ACC_W-1], pend_sum};
  assign round_k = ((ACC_W+1)'(1) << pend_shift) >> 1;
  assign rnd     = wide + round_k;
  assign shifted = rnd >>> pend_shift;

  always_comb begin
    q     = shifted[OUT_W-1:0];
    clamp = 1'b0;
    if (shifted > Q_MAX) begin
      q     = {1'b0, {(OUT_W-1){1'b1}}};
      clamp = 1'b1;
    end
`ifdef NPU_ACC_RELU_EN
    else if (shifted[ACC_W]) begin
      q = '0;
    end
`else
    else if (shifted < Q_MIN) begin
      q     = {1'b1, {(OUT_W-1){1'b0}}};
      clamp = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc        <= '0;
      pend_valid <= 1'b0;
      pend_sum   <= '0;
      pend_shift <= '0;
    end else begin
      if (accept) begin
        if (in_last) begin
          pend_sum   <= sum2;
          pend_shift <= shift_eff;
          acc        <= '0;
        end else begin
          acc <= sum1;
        end
      end
      if (accept && in_last) begin
        pend_valid <= 1'b1;
      end else if (xfer) begin
        pend_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= q;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovf_flag <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      if (ovf_hit) begin
        ovf_flag <= 1'b1;
      end
      if (xfer && clamp) begin
        sat_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_npu_mac_accum.sv
// tb_npu_mac_accum: directed bench for npu_mac_accum with a
// queue-based reference model and literal expectations.
module tb_npu_mac_accum;

`ifdef NPU_ACC_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  localparam longint P47 = longint'(1) << 47;
  localparam longint P48 = longint'(1) << 48;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [36:0] in_data = '0;
  logic        in_last = 1'b0;
  logic [31:0] bias = '0;
  logic [5:0]  shift_amt = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        ovf_flag;
  logic        sat_flag;

  npu_mac_accum dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .bias      (bias),
    .shift_amt (shift_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ovf_flag  (ovf_flag),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  longint m_acc = 0;
  bit     m_ovf = 1'b0;
  int     exp_q[$];
  bit     sat_q[$];
  int     occ = 0;
  bit     prev_hold = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic longint wrap48(input longint x);
    longint y;
    y = x & (P48 - 1);
    if (y >= P47) y -= P48;
    return y;
  endfunction

  function automatic longint madd(input longint a, input longint b);
    longint x;
    x = a + b;
    if (x > P47 - 1 || x < -P47) m_ovf = 1'b1;
    return wrap48(x);
  endfunction

  // Round half up, then floor-divide by 2^s, then clamp.
  function automatic int requant(input longint sum, input int s_in,
                                 output bit sat);
    longint d, n, qv;
    int s;
    s = (s_in > 47) ? 47 : s_in;
    sat = 1'b0;
    if (s == 0) begin
      qv = sum;
    end else begin
      d  = longint'(1) << s;
      n  = sum + d / 2;
      qv = n / d;
      if ((n % d) != 0 && n < 0) qv -= 1;
    end
    if (qv > 127) begin
      qv = 127;
      sat = 1'b1;
    end else if (RELU && qv < 0) begin
      qv = 0;
    end else if (qv < -128) begin
      qv = -128;
      sat = 1'b1;
    end
    return int'(qv);
  endfunction

  always @(negedge clk) begin
    bit     acc_t;
    bit     pop_t;
    bit     es;
    bit     sb;
    int     e;
    longint s2;
    if (!reset_n) begin
      m_acc = 0;
      m_ovf = 1'b0;
      exp_q.delete();
      sat_q.delete();
      occ = 0;
      prev_hold = 1'b0;
    end else begin
      acc_t = in_valid && in_ready;
      pop_t = out_valid && out_ready;
      chk("in_ready", longint'(in_ready),
          longint'((occ < 2) || out_ready));
      chk("ovf_flag", longint'(ovf_flag), longint'(m_ovf));
      if (prev_hold)
        chk("out_hold", longint'(out_data), longint'(prev_data));
      if (pop_t) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_out actual=%0d required=none",
                   $signed(out_data));
        end else begin
          e  = exp_q.pop_front();
          es = sat_q.pop_front();
          chk("out_data", longint'($signed(out_data)), longint'(e));
          if (es) chk("sat_flag", longint'(sat_flag), 1);
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      if (acc_t) begin
        m_acc = madd(m_acc, longint'($signed(in_data)));
        if (in_last) begin
          s2 = madd(m_acc, longint'($signed(bias)));
          exp_q.push_back(requant(s2, int'(shift_amt), sb));
          sat_q.push_back(sb);
          m_acc = 0;
        end
      end
      occ += int'(acc_t && in_last) - int'(pop_t);
    end
  end

  task automatic beat(input longint d, input bit last,
                      input longint b = 0, input int s = 0);
    in_data   = 37'(d);
    in_last   = last;
    bias      = 32'(b);
    shift_amt = 6'(s);
    in_valid  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL beat_timeout actual=stalled required=accept");
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_out(input int v, input string name);
    @(negedge clk);
    @(negedge clk);
    chk({name, "_valid"}, longint'(out_valid), 1);
    chk(name, longint'($signed(out_data)), longint'(v));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_ovf", longint'(ovf_flag), 0);
    chk("rst_sat", longint'(sat_flag), 0);
    chk("rst_in_ready", longint'(in_ready), 1);
    @(posedge clk);
    #1;

    beat(2, 0);
    beat(3, 0);
    beat(5, 1, 0, 0);
    expect_out(10, "sum10");
    chk("sum10_ovf", longint'(ovf_flag), 0);
    chk("sum10_sat", longint'(sat_flag), 0);

    beat(2, 0);
    beat(3, 0);
    beat(5, 1, 2, 2);
    expect_out(3, "round_pos");

    beat(-2, 0);
    beat(-3, 0);
    beat(-5, 1, 0, 2);
    expect_out(RELU ? 0 : -2, "round_neg");
    chk("round_neg_sat", longint'(sat_flag), 0);

    beat(-(longint'(1) << 36), 1, 0, 63);
    expect_out(0, "shift_clamp");

    beat(1000, 1);
    expect_out(127, "sat_hi");
    chk("sat_hi_flag", longint'(sat_flag), 1);

    do_reset();
    beat(-1000, 1);
    expect_out(RELU ? 0 : -128, "sat_lo");
    chk("sat_lo_flag", longint'(sat_flag), RELU ? 0 : 1);

    out_ready = 1'b0;
    beat(1, 1);
    beat(2, 1);
    fork
      beat(3, 1);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready", longint'(in_ready), 0);
          chk("bp_out_valid", longint'(out_valid), 1);
          chk("bp_out_data", longint'(out_data), 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (5) @(posedge clk);
    #1;
    chk("bp_drain", longint'(exp_q.size()), 0);

    for (int i = 0; i < 2048; i++)
      beat((longint'(1) << 36) - 1, 0);
    @(negedge clk);
    chk("ovf_edge_pre", longint'(ovf_flag), 0);
    @(posedge clk);
    #1;
    beat((longint'(1) << 36) - 1, 0);
    @(negedge clk);
    chk("ovf_edge_post", longint'(ovf_flag), 1);
    @(posedge clk);
    #1;
    beat(0, 1);
    expect_out(RELU ? 0 : -128, "ovf_wrap");
    beat(5, 1);
    expect_out(5, "after_ovf");
    chk("ovf_sticky", longint'(ovf_flag), 1);

    beat(7, 0);
    beat(9, 0);
    do_reset();
    @(negedge clk);
    chk("rst2_ovf", longint'(ovf_flag), 0);
    chk("rst2_sat", longint'(sat_flag), 0);
    @(posedge clk);
    #1;
    beat(4, 1);
    expect_out(4, "acc_cleared");

    repeat (4) @(posedge clk);
    #1;
    chk("final_drain", longint'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/npu_mac_accum.md
# npu_mac_accum

Accumulate-and-requantize stage directly downstream of the Gowin_MULTADDALU dual multiply-add. It sums the signed 37-bit `dout` products of one dot product, adds a per-output bias, then rounds, shifts and saturates the total to a signed 8-bit activation. The result is presented on a valid/ready output toward the NPU activation writeback. The upstream sequencer aligns `in_valid`/`in_last` with MULTADDALU latency.

## Interface
- `IN_W`, 37, product width (MULTADDALU `dout`), signed
- `ACC_W`, 48, accumulator width, signed
- `BIAS_W`, 32, bias width, signed
- `OUT_W`, 8, output activation width, signed
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  synchronous active-low reset
- `in_valid`  in  1  product beat valid
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`
- `in_data`  in  IN_W  signed product-pair sum
- `in_last`  in  1  final beat of the current dot product
- `bias`  in  BIAS_W  signed bias, sampled with the `in_last` beat
- `shift_amt`  in  6  right-shift amount 0..47, sampled with the `in_last` beat
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accept
- `out_data`  out  OUT_W  saturated result
- `ovf_flag`  out  1  sticky: accumulator overflow since reset
- `sat_flag`  out  1  sticky: output saturation since reset

## Operation
- Accumulator `acc` (ACC_W) resets to 0. On an accepted non-last beat: `acc <= acc + sext(in_data)`.
- On an accepted last beat: `pend_sum <= acc + sext(in_data) + sext(bias)`. Latch `pend_shift <= shift_amt`, set `pend_valid`, clear `acc` to 0 in the same edge.
- Requantization of `pend_sum` with shift s is combinational:
  - s = 0: r = pend_sum.
  - s > 0: r = (pend_sum + 2^(s-1)) >>> s (arithmetic shift; round half toward +inf).
  - The rounding add is computed at ACC_W+1 bits, so it never wraps.
  - Saturate r to [-128, 127]. Set `sat_flag` when clamping occurs.
- Transfer: when `pend_valid && (!out_valid || out_ready)`, load `out_data` with the saturated r, set `out_valid`, clear `pend_valid`. If there is no new transfer, `out_valid` clears on `out_ready`.
- `in_ready = !pend_valid || !out_valid || out_ready` (combinational). Non-last beats are also stalled by this rule; the design has no separate path for them.
- Overflow: if any accumulate or bias add overflows signed ACC_W, set `ovf_flag`. The result wraps (two's complement); it does not saturate.
- `shift_amt` > 47 is treated as 47.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `ovf_flag`=0, `sat_flag`=0, `acc`=0, `pend_valid`=0. `in_ready`=1 after reset.
- Latency: a last beat accepted at edge N produces `out_valid`=1 after edge N+1, provided the output is free.
- Throughput: one beat per cycle with no backpressure. Single-beat dot products (`in_last` on every beat) sustain one result per cycle.
- Backpressure: with `out_valid` held and `out_ready`=0, one further dot product completes into `pend`. `in_ready` then drops until `out_ready`.
- Simultaneous events:
  - Output pop plus pend transfer in the same cycle: new data is loaded and `out_valid` stays 1.
  - Last beat accepted while pend transfers in the same cycle: pend reloads.
- `out_data` is stable while `out_valid && !out_ready`.
- Reset mid-operation: a partial `acc` and any pending or output result are discarded. Sticky flags are cleared.

## Configuration
- `NPU_ACC_RELU_EN` defined:
  - A negative requantized result outputs 0 instead of the negative value.
  - Clamping to 0 does not set `sat_flag`.
  - The upper clamp of 127 is unchanged.
- `NPU_ACC_RELU_EN` undefined: full signed range [-128, 127] is output.

## Test plan
- Beats 2, 3, then last 5; bias 0, shift 0 -> `out_data`=10 one cycle after the last edge. Flags stay 0.
- Same beats with bias 2, shift 2 -> sum 12, (12+2)>>>2 = 3 -> `out_data`=3. Repeat with sum -10, shift 2 -> -2.
- Single last beat 1000, shift 0 -> 127, `sat_flag`=1. Beat -1000 -> -128. With `NPU_ACC_RELU_EN`, -1000 -> 0 and `sat_flag` stays 0.
- Hold `out_ready`=0 and stream three single-beat dot products 1, 2, 3:
  - outputs 1 (held) and 2 (pend) are captured;
  - `in_ready` drops while 3 waits;
  - release `out_ready` -> 1, 2, 3 emitted in order, none lost or duplicated.
- Accumulate repeated max-positive 37-bit products until the sum exceeds 2^47-1 -> `ovf_flag`=1 and stays set.
- Assert `reset_n`=0 for one cycle after two non-last beats. Then send last beat 4 -> `out_data`=4, proving `acc` was cleared.
